// File: rtl/pc_gen_pkg.sv
// Shared types and default parameters for the program-counter generator.
package pc_gen_pkg;

  localparam int unsigned XLEN_DEFAULT         = 64;
  localparam int unsigned NUM_REDIR_DEFAULT    = 3;
  localparam int unsigned FETCH_BYTES_DEFAULT  = 4;
  localparam int unsigned FLUSH_CYCLES_DEFAULT = 1;
  localparam int unsigned EPOCH_W_DEFAULT      = 4;
  localparam int unsigned FLUSH_CNT_W          = 4;

  localparam logic [63:0] START_ADDR_DEFAULT = 64'h0000_0000_8000_0000;

  // Fetch-address generator control states
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FAULT = 2'd3
  } pc_state_e;

endpackage : pc_gen_pkg

// File: rtl/pc_redir_sel.sv
// Fixed-priority redirect selector: lowest-index valid channel wins.
module pc_redir_sel
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEFAULT,
  parameter int unsigned NUM_REDIR = NUM_REDIR_DEFAULT
) (
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc,
  output logic [NUM_REDIR-1:0]      grant_c,
  output logic [XLEN-1:0]           target_c
);

  // Isolate the lowest set bit to form a one-hot grant
  always_comb begin
    grant_c = redir_valid & (~redir_valid + NUM_REDIR'(1));
  end

  // AND-OR mux of the granted channel's target
  always_comb begin
    target_c = '0;
    for (int unsigned k = 0; k < NUM_REDIR; k++) begin
      target_c = target_c | ({XLEN{grant_c[k]}} & redir_pc[k*XLEN +: XLEN]);
    end
  end

endmodule : pc_redir_sel

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential advance, prioritised redirects with
// epoch tagging, post-redirect flush bubbles and misalignment fault.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEFAULT,
  parameter logic [63:0] START_ADDR   = START_ADDR_DEFAULT,
  parameter int unsigned NUM_REDIR    = NUM_REDIR_DEFAULT,
  parameter int unsigned FETCH_BYTES  = FETCH_BYTES_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
  parameter int unsigned EPOCH_W      = EPOCH_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc,
  input  logic                      stall,
  input  logic                      pc_ready,
  output logic [XLEN-1:0]           pc_o,
  output logic                      pc_valid,
  output logic [EPOCH_W-1:0]        epoch_o,
  output logic                      misalign_o
);

  localparam int unsigned OFF_W = $clog2(FETCH_BYTES);

  // Parameter sanity: power-of-two fetch width >= 2, flush length fits counter
  if (FETCH_BYTES < 2 || (FETCH_BYTES & (FETCH_BYTES - 1)) != 0) begin : g_bad_fetch
    $error("pc_gen: FETCH_BYTES must be a power of two >= 2");
  end
  if (FLUSH_CYCLES > 15) begin : g_bad_flush
    $error("pc_gen: FLUSH_CYCLES must be 0..15");
  end

  pc_state_e               state;
  logic [FLUSH_CNT_W-1:0]  flush_cnt;

  logic [NUM_REDIR-1:0]    sel_grant_c;
  logic [XLEN-1:0]         sel_target_c;
  logic                    redir_c;
  logic                    target_misaligned_c;
  logic                    fire_c;

  pc_redir_sel #(
    .XLEN      (XLEN),
    .NUM_REDIR (NUM_REDIR)
  ) u_redir_sel (
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .grant_c     (sel_grant_c),
    .target_c    (sel_target_c)
  );

  // Redirect qualification and fetch handshake
  always_comb begin
    redir_c             = |sel_grant_c;
    target_misaligned_c = |sel_target_c[OFF_W-1:0];
    fire_c              = pc_valid & pc_ready & ~stall;
  end

  // Control FSM with registered outputs; redirects pre-empt every state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BOOT;
      pc_o       <= XLEN'(START_ADDR);
      pc_valid   <= 1'b0;
      epoch_o    <= '0;
      misalign_o <= 1'b0;
      flush_cnt  <= '0;
    end else if (redir_c) begin
      pc_o    <= sel_target_c;
      epoch_o <= epoch_o + EPOCH_W'(1);
      if (target_misaligned_c) begin
        state      <= ST_FAULT;
        misalign_o <= 1'b1;
        pc_valid   <= 1'b0;
        flush_cnt  <= '0;
      end else begin
        misalign_o <= 1'b0;
        if (FLUSH_CYCLES == 0) begin
          state     <= ST_RUN;
          pc_valid  <= 1'b1;
          flush_cnt <= '0;
        end else begin
          state     <= ST_FLUSH;
          pc_valid  <= 1'b0;
          flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES);
        end
      end
    end else begin
      case (state)
        ST_BOOT: begin
          state    <= ST_RUN;
          pc_valid <= 1'b1;
        end
        ST_RUN: begin
          pc_valid <= 1'b1;
          if (fire_c) begin
            pc_o <= pc_o + XLEN'(FETCH_BYTES);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt <= FLUSH_CNT_W'(1)) begin
            state     <= ST_RUN;
            pc_valid  <= 1'b1;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
          end
        end
        ST_FAULT: begin
          pc_valid   <= 1'b0;
          misalign_o <= 1'b1;
        end
        default: begin
          state    <= ST_BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model.
module tb_pc_gen;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NR    = 3;
  localparam int unsigned FB    = 4;
  localparam int unsigned FC    = 1;
  localparam int unsigned EW    = 4;
  localparam logic [63:0] START = 64'h0000_0000_8000_0000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        redir_valid;
  logic [NR*XLEN-1:0]   redir_pc;
  logic                 stall;
  logic                 pc_ready;
  logic [XLEN-1:0]      pc_o;
  logic                 pc_valid;
  logic [EW-1:0]        epoch_o;
  logic                 misalign_o;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN         (XLEN),
    .START_ADDR   (START),
    .NUM_REDIR    (NR),
    .FETCH_BYTES  (FB),
    .FLUSH_CYCLES (FC),
    .EPOCH_W      (EW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .stall       (stall),
    .pc_ready    (pc_ready),
    .pc_o        (pc_o),
    .pc_valid    (pc_valid),
    .epoch_o     (epoch_o),
    .misalign_o  (misalign_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: what the fetch interface must look like
  logic [63:0] m_pc;
  logic        m_valid;
  logic        m_mis;
  logic        m_boot;
  int          m_bub;
  int          m_epoch;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    int          win;
    logic [63:0] tgt;
    win = -1;
    for (int k = NR - 1; k >= 0; k--) if (redir_valid[k]) win = k;
    if (rst) begin
      m_pc = START; m_valid = 1'b0; m_mis = 1'b0; m_boot = 1'b1; m_bub = 0; m_epoch = 0;
    end else if (win >= 0) begin
      tgt     = redir_pc[win*XLEN +: XLEN];
      m_pc    = tgt;
      m_epoch = (m_epoch + 1) % (1 << EW);
      m_boot  = 1'b0;
      if ((tgt % FB) != 0) begin
        m_mis = 1'b1; m_valid = 1'b0; m_bub = 0;
      end else begin
        m_mis   = 1'b0;
        m_bub   = FC;
        m_valid = (FC == 0);
      end
    end else if (m_mis) begin
      m_valid = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_valid = 1'b1;
    end else if (m_bub > 0) begin
      m_bub--;
      if (m_bub == 0) m_valid = 1'b1;
    end else if (m_valid && pc_ready && !stall) begin
      m_pc = m_pc + 64'(FB);
    end
  endtask

  // One clock: update model, then sample DUT away from the edge and compare
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("pc_o",       pc_o,              m_pc);
    check("pc_valid",   64'(pc_valid),     64'(m_valid));
    check("epoch_o",    64'(epoch_o),      64'(m_epoch));
    check("misalign_o", 64'(misalign_o),   64'(m_mis));
  endtask

  task automatic redir(input int k, input logic [63:0] addr);
    redir_valid    = '0;
    redir_valid[k] = 1'b1;
    redir_pc[k*XLEN +: XLEN] = addr;
  endtask

  function automatic logic [63:0] rand_target();
    logic [63:0] a;
    int          r;
    a = {$urandom, $urandom};
    r = $urandom_range(0, 9);
    if (r < 5)       a = a & ~64'(FB - 1);
    else if (r == 5) a = (a & ~64'(FB - 1)) | 64'($urandom_range(1, FB - 1));
    else if (r < 8)  a = 64'hFFFF_FFFF_FFFF_FF00 | (a & 64'hF0);
    else             a = 64'h8000_0000 + ((a & 64'hFF) << 2);
    return a;
  endfunction

  initial begin
    rst = 1'b1; redir_valid = '0; redir_pc = '0; stall = 1'b0; pc_ready = 1'b1;

    // Reset and boot sequence
    tick(); tick();
    check("rst_pc",    pc_o, 64'h8000_0000);
    check("rst_valid", 64'(pc_valid), 64'd0);
    rst = 1'b0;
    tick();
    check("boot_first_pc",  pc_o, 64'h8000_0000);
    check("boot_first_val", 64'(pc_valid), 64'd1);
    tick();
    check("seq_pc4", pc_o, 64'h8000_0004);
    tick();
    check("seq_pc8", pc_o, 64'h8000_0008);

    // Two channels at once: lower index wins, one bubble
    redir_valid = 3'b110;
    redir_pc[1*XLEN +: XLEN] = 64'h100;
    redir_pc[2*XLEN +: XLEN] = 64'h200;
    tick();
    check("prio_pc",    pc_o, 64'h100);
    check("prio_epoch", 64'(epoch_o), 64'd1);
    check("prio_bubble",64'(pc_valid), 64'd0);
    redir_valid = '0;
    tick();
    check("prio_valid", 64'(pc_valid), 64'd1);
    check("prio_hold",  pc_o, 64'h100);
    tick();

    // Redirect overrides stall; pc holds while stalled
    stall = 1'b1;
    redir(0, 64'h40);
    tick();
    check("stall_redir_pc", pc_o, 64'h40);
    redir_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_hold", pc_o, 64'h40);
    end
    stall = 1'b0;

    // Misaligned target faults until an aligned redirect
    redir(0, 64'h102);
    tick();
    check("fault_mis",   64'(misalign_o), 64'd1);
    check("fault_valid", 64'(pc_valid), 64'd0);
    redir_valid = '0;
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom); pc_ready = 1'($urandom);
      tick();
    end
    check("fault_held_pc", pc_o, 64'h102);
    stall = 1'b0; pc_ready = 1'b1;
    redir(0, 64'h104);
    tick();
    check("fault_clear", 64'(misalign_o), 64'd0);
    redir_valid = '0;
    tick();
    check("fault_resume_pc",  pc_o, 64'h104);
    check("fault_resume_val", 64'(pc_valid), 64'd1);

    // Address wrap at the top of the space
    redir(2, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    redir_valid = '0;
    tick();
    tick();
    check("pc_wrap", pc_o, 64'h0);

    // Sixteen redirects wrap the epoch back to zero
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      redir(i % NR, 64'h1000 + 64'(i * 4));
      tick();
    end
    redir_valid = '0;
    check("epoch_wrap", 64'(epoch_o), 64'd0);
    check("epoch_wrap_pc", pc_o, 64'h103C);

    // Reset dominates a redirect while flushing
    redir(1, 64'h2000);
    tick();
    rst = 1'b1;
    redir(0, 64'h3000);
    tick();
    check("rst_dom_pc",    pc_o, 64'h8000_0000);
    check("rst_dom_epoch", 64'(epoch_o), 64'd0);
    check("rst_dom_valid", 64'(pc_valid), 64'd0);
    rst = 1'b0; redir_valid = '0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      redir_valid = ($urandom_range(0, 5) == 0) ? NR'($urandom) : '0;
      for (int k = 0; k < NR; k++) redir_pc[k*XLEN +: XLEN] = rand_target();
      stall    = ($urandom_range(0, 3) == 0);
      pc_ready = ($urandom_range(0, 4) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_gen

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter: XLEN, 64, PC width in bits.
REQ-002 Parameter: START_ADDR, 64'h8000_0000, PC value loaded at reset.
REQ-003 Parameter: NUM_REDIR, 3, number of redirect channels; channel 0 has the highest priority.
REQ-004 Parameter: FETCH_BYTES, 4, sequential increment; SHALL be a power of two, minimum 2.
REQ-005 Parameter: FLUSH_CYCLES, 1, bubble cycles after a redirect; SHALL be 0..15.
REQ-006 Parameter: EPOCH_W, 4, width of the redirect epoch counter.
REQ-007 clk  in  1  clock; all state updates on its rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 redir_valid  in  NUM_REDIR  per-channel redirect request.
REQ-010 redir_pc  in  NUM_REDIR*XLEN  per-channel target; channel k occupies bits [k*XLEN +: XLEN].
REQ-011 stall  in  1  pipeline stall; blocks sequential advance only.
REQ-012 pc_ready  in  1  IF stage accepts pc_o this cycle.
REQ-013 pc_o  out  XLEN  current fetch address (registered).
REQ-014 pc_valid  out  1  pc_o is presentable to IF (registered).
REQ-015 epoch_o  out  EPOCH_W  redirect generation tag; IF uses it to discard stale responses.
REQ-016 misalign_o  out  1  current pc_o is not FETCH_BYTES-aligned; fetch is suppressed.

Function
REQ-017 States: BOOT, RUN, FLUSH, FAULT; the state is a registered enum.
REQ-018 fire = pc_valid & pc_ready & ~stall.
REQ-019 Redirect selection: the lowest-index asserted redir_valid wins; all other channels are ignored that cycle.
REQ-020 A redirect in any state except reset SHALL load pc_o with the selected target on the next edge and SHALL increment epoch_o modulo 2^EPOCH_W.
REQ-021 A redirect SHALL override stall, pc_ready and any flush in progress.
REQ-022 If the redirect target has nonzero low log2(FETCH_BYTES) bits, the block SHALL enter FAULT with misalign_o=1 and pc_valid=0.
REQ-023 If the redirect target is aligned: FLUSH_CYCLES=0 -> go to RUN; otherwise go to FLUSH and load the down-counter with FLUSH_CYCLES.
REQ-024 FLUSH: pc_valid=0, pc_o held, counter decrements each cycle; the state goes to RUN in the cycle after the counter reaches 1.
REQ-025 A redirect during FLUSH SHALL reload the counter (restart).
REQ-026 RUN with no redirect: on fire, pc_o <= pc_o + FETCH_BYTES, wrapping modulo 2^XLEN; otherwise pc_o is held.
REQ-027 In RUN, pc_valid=1.
REQ-028 FAULT is left only on an aligned redirect, which clears misalign_o; stall and pc_ready have no effect in FAULT.
REQ-029 BOOT lasts exactly one cycle after rst deasserts with pc_valid=0, then goes to RUN (a redirect in BOOT follows REQ-020..023).
REQ-030 Redirect-to-pc_o latency: 1 cycle. pc_valid reasserts FLUSH_CYCLES+1 cycles after the redirect cycle.

Reset
REQ-031 On rst: pc_o=START_ADDR, pc_valid=0, epoch_o=0, misalign_o=0, flush counter=0, state=BOOT.
REQ-032 rst SHALL dominate redirects and stall in the same cycle.
REQ-033 rst asserted mid-FLUSH or mid-FAULT SHALL fully abort to the reset values.

Structure
REQ-034 Package pc_gen_pkg SHALL hold the state enum, START_ADDR default, and FETCH_BYTES/EPOCH_W defaults.
REQ-035 Sub-module pc_redir_sel SHALL implement the parametrised priority select (one-hot grant plus selected target, purely combinational).
REQ-036 No other sub-modules; all outputs are registered.

Verification
REQ-037 Reset release, pc_ready=1, stall=0 -> pc_o=0x8000_0000 with pc_valid=0 for 1 cycle, then 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles.
REQ-038 Channels 1 and 2 asserted together (targets 0x100 and 0x200) with FLUSH_CYCLES=1 -> pc_o=0x100 next cycle, epoch 0->1, one bubble, then pc_valid=1 at 0x100.
REQ-039 stall=1 with channel 0 redirect to 0x40 in the same cycle -> pc_o=0x40 next cycle; pc_o holds at 0x40 while stall remains high.
REQ-040 Redirect to 0x102 (FETCH_BYTES=4) -> FAULT, misalign_o=1, pc_valid=0 held 10 cycles; then redirect to 0x104 -> misalign_o=0, RUN resumes at 0x104.
REQ-041 pc_o=0xFFFF_FFFF_FFFF_FFFC followed by fire -> pc_o=0; also 16 redirects with EPOCH_W=4 -> epoch_o wraps to 0.
REQ-042 rst asserted during FLUSH with a simultaneous redirect -> all outputs at reset values next cycle, epoch_o=0.
